// File: rtl/network_output_desc_sched.sv
// Per-port output descriptor scheduler: two-source round-robin intake into TS/BE
// queues, strict-priority TS dispatch with a gated BE class, one dispatch in flight per port.
module network_output_desc_sched #(
  parameter int unsigned PORT_NUM    = 2,
  parameter int unsigned DESC_DEPTH  = 16,
  parameter logic [2:0]  TS_TYPE_MAX = 3'd2
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst,
  input  logic [48*PORT_NUM-1:0]                      iv_tsntag_host,
  input  logic [3*PORT_NUM-1:0]                       iv_pkt_type_host,
  input  logic [9*PORT_NUM-1:0]                       iv_bufid_host,
  input  logic [PORT_NUM-1:0]                         i_descriptor_wr_host,
  output logic [PORT_NUM-1:0]                         o_descriptor_ack_host,
  input  logic [48*PORT_NUM-1:0]                      iv_tsntag_network,
  input  logic [3*PORT_NUM-1:0]                       iv_pkt_type_network,
  input  logic [9*PORT_NUM-1:0]                       iv_bufid_network,
  input  logic [PORT_NUM-1:0]                         i_descriptor_wr_network,
  output logic [PORT_NUM-1:0]                         o_descriptor_ack_network,
  input  logic [PORT_NUM-1:0]                         iv_be_gate,
  output logic [9*PORT_NUM-1:0]                       ov_pkt_bufid,
  output logic [48*PORT_NUM-1:0]                      ov_tsntag,
  output logic [3*PORT_NUM-1:0]                       ov_pkt_type,
  output logic [PORT_NUM-1:0]                         o_pkt_bufid_wr,
  input  logic [PORT_NUM-1:0]                         i_pkt_bufid_ack,
  output logic [PORT_NUM-1:0]                         o_pkt_output_pulse,
  output logic [($clog2(DESC_DEPTH)+1)*PORT_NUM-1:0]  ov_ts_used,
  output logic [($clog2(DESC_DEPTH)+1)*PORT_NUM-1:0]  ov_be_used
);

  localparam int unsigned AW = $clog2(DESC_DEPTH);
  localparam int unsigned UW = AW + 1;
  localparam int unsigned DW = 60;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_ACK
  } state_e;

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
    logic [DW-1:0] h_data, n_data, push_data, pop_data;
    logic          h_is_ts, n_is_ts;

    logic [DW-1:0] ts_mem [DESC_DEPTH];
    logic [DW-1:0] be_mem [DESC_DEPTH];
    logic [UW-1:0] ts_wptr_q, ts_wptr_d, ts_rptr_q, ts_rptr_d;
    logic [UW-1:0] be_wptr_q, be_wptr_d, be_rptr_q, be_rptr_d;
    logic [UW-1:0] ts_used_q, ts_used_d, be_used_q, be_used_d;
    logic          ts_full, ts_empty, be_full, be_empty;
    logic          ts_room, be_room;
    logic          ts_push, be_push, ts_pop, be_pop;

    logic          ack_h_q, ack_h_d, ack_n_q, ack_n_d;
    logic          rr_q, rr_d;
    logic          h_elig, n_elig, grant_h, grant_n;

    state_e        state_q, state_d;
    logic          wr_q, wr_d;
    logic [DW-1:0] out_q, out_d;
    logic          pulse;

    assign h_data  = {iv_tsntag_host[p*48 +: 48], iv_pkt_type_host[p*3 +: 3],
                      iv_bufid_host[p*9 +: 9]};
    assign n_data  = {iv_tsntag_network[p*48 +: 48], iv_pkt_type_network[p*3 +: 3],
                      iv_bufid_network[p*9 +: 9]};
    assign h_is_ts = (iv_pkt_type_host[p*3 +: 3] <= TS_TYPE_MAX);
    assign n_is_ts = (iv_pkt_type_network[p*3 +: 3] <= TS_TYPE_MAX);

    assign ts_empty = (ts_wptr_q == ts_rptr_q);
    assign be_empty = (be_wptr_q == be_rptr_q);
    assign ts_full  = (ts_wptr_q[AW-1:0] == ts_rptr_q[AW-1:0]) && (ts_wptr_q[AW] != ts_rptr_q[AW]);
    assign be_full  = (be_wptr_q[AW-1:0] == be_rptr_q[AW-1:0]) && (be_wptr_q[AW] != be_rptr_q[AW]);

    // Pop decisions depend only on queue state and the gate, so a full queue
    // being popped this cycle can still accept a push without a comb loop.
    assign ts_room = !ts_full || ts_pop;
    assign be_room = !be_full || be_pop;

    assign h_elig = i_descriptor_wr_host[p] && !ack_h_q && (h_is_ts ? ts_room : be_room);
    assign n_elig = i_descriptor_wr_network[p] && !ack_n_q && (n_is_ts ? ts_room : be_room);

    always_comb begin
      grant_h = 1'b0;
      grant_n = 1'b0;
      rr_d    = rr_q;
      if (h_elig && n_elig) begin
        grant_h = !rr_q;
        grant_n = rr_q;
        rr_d    = !rr_q;
      end else if (h_elig) begin
        grant_h = 1'b1;
        rr_d    = 1'b1;
      end else if (n_elig) begin
        grant_n = 1'b1;
        rr_d    = 1'b0;
      end
    end

    assign ack_h_d   = grant_h;
    assign ack_n_d   = grant_n;
    assign push_data = grant_n ? n_data : h_data;
    assign ts_push   = (grant_h && h_is_ts) || (grant_n && n_is_ts);
    assign be_push   = (grant_h && !h_is_ts) || (grant_n && !n_is_ts);

    always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      ts_pop  = 1'b0;
      be_pop  = 1'b0;
      pulse   = 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (!ts_empty) begin
            ts_pop  = 1'b1;
            wr_d    = 1'b1;
            state_d = S_LOAD;
          end else if (!be_empty && iv_be_gate[p]) begin
            be_pop  = 1'b1;
            wr_d    = 1'b1;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          state_d = S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (i_pkt_bufid_ack[p]) begin
            wr_d    = 1'b0;
            pulse   = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: begin
          wr_d    = 1'b0;
          state_d = S_IDLE;
        end
      endcase
    end

    assign pop_data = ts_pop ? ts_mem[ts_rptr_q[AW-1:0]] : be_mem[be_rptr_q[AW-1:0]];
    assign out_d    = (ts_pop || be_pop) ? pop_data : out_q;

    always_comb begin
      ts_wptr_d = ts_push ? ts_wptr_q + UW'(1) : ts_wptr_q;
      be_wptr_d = be_push ? be_wptr_q + UW'(1) : be_wptr_q;
      ts_rptr_d = ts_pop  ? ts_rptr_q + UW'(1) : ts_rptr_q;
      be_rptr_d = be_pop  ? be_rptr_q + UW'(1) : be_rptr_q;
      ts_used_d = ts_used_q;
      be_used_d = be_used_q;
      if (ts_push && !ts_pop) begin
        ts_used_d = ts_used_q + UW'(1);
      end else if (!ts_push && ts_pop) begin
        ts_used_d = ts_used_q - UW'(1);
      end
      if (be_push && !be_pop) begin
        be_used_d = be_used_q + UW'(1);
      end else if (!be_push && be_pop) begin
        be_used_d = be_used_q - UW'(1);
      end
    end

    always_ff @(posedge i_clk) begin
      if (ts_push) begin
        ts_mem[ts_wptr_q[AW-1:0]] <= push_data;
      end
      if (be_push) begin
        be_mem[be_wptr_q[AW-1:0]] <= push_data;
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        ts_wptr_q <= '0;
        ts_rptr_q <= '0;
        be_wptr_q <= '0;
        be_rptr_q <= '0;
        ts_used_q <= '0;
        be_used_q <= '0;
        ack_h_q   <= 1'b0;
        ack_n_q   <= 1'b0;
        rr_q      <= 1'b0;
        state_q   <= S_IDLE;
        wr_q      <= 1'b0;
        out_q     <= '0;
      end else begin
        ts_wptr_q <= ts_wptr_d;
        ts_rptr_q <= ts_rptr_d;
        be_wptr_q <= be_wptr_d;
        be_rptr_q <= be_rptr_d;
        ts_used_q <= ts_used_d;
        be_used_q <= be_used_d;
        ack_h_q   <= ack_h_d;
        ack_n_q   <= ack_n_d;
        rr_q      <= rr_d;
        state_q   <= state_d;
        wr_q      <= wr_d;
        out_q     <= out_d;
      end
    end

    assign o_descriptor_ack_host[p]    = ack_h_q;
    assign o_descriptor_ack_network[p] = ack_n_q;
    assign o_pkt_bufid_wr[p]           = wr_q;
    assign o_pkt_output_pulse[p]       = pulse;
    assign ov_tsntag[p*48 +: 48]       = out_q[59:12];
    assign ov_pkt_type[p*3 +: 3]       = out_q[11:9];
    assign ov_pkt_bufid[p*9 +: 9]      = out_q[8:0];
    assign ov_ts_used[p*UW +: UW]      = ts_used_q;
    assign ov_be_used[p*UW +: UW]      = be_used_q;
  end

endmodule

// File: tb/tb_network_output_desc_sched.sv
// Directed bench for network_output_desc_sched with four ports: intake timing,
// round-robin, TS priority and BE gating, full-queue backpressure, wrap, reset flush.
module tb_network_output_desc_sched;
  localparam int PN = 4;
  localparam int UW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [48*PN-1:0] tag_h, tag_n, otag;
  logic [3*PN-1:0]  typ_h, typ_n, otyp;
  logic [9*PN-1:0]  buf_h, buf_n, obuf;
  logic [PN-1:0]    wr_h, wr_n, ack_h, ack_n, gate, bwr, back, pulse;
  logic [UW*PN-1:0] ts_used, be_used;

  network_output_desc_sched #(
    .PORT_NUM   (PN),
    .DESC_DEPTH (16),
    .TS_TYPE_MAX(3'd2)
  ) dut (
    .i_clk                   (clk),
    .i_rst                   (rst),
    .iv_tsntag_host          (tag_h),
    .iv_pkt_type_host        (typ_h),
    .iv_bufid_host           (buf_h),
    .i_descriptor_wr_host    (wr_h),
    .o_descriptor_ack_host   (ack_h),
    .iv_tsntag_network       (tag_n),
    .iv_pkt_type_network     (typ_n),
    .iv_bufid_network        (buf_n),
    .i_descriptor_wr_network (wr_n),
    .o_descriptor_ack_network(ack_n),
    .iv_be_gate              (gate),
    .ov_pkt_bufid            (obuf),
    .ov_tsntag               (otag),
    .ov_pkt_type             (otyp),
    .o_pkt_bufid_wr          (bwr),
    .i_pkt_bufid_ack         (back),
    .o_pkt_output_pulse      (pulse),
    .ov_ts_used              (ts_used),
    .ov_be_used              (be_used)
  );

  logic [11:0] hlist [PN][64];
  logic [11:0] nlist [PN][64];
  int          hn [PN], hi [PN], nn [PN], ni [PN];
  logic [8:0]  got [PN][64];
  int          gn [PN];
  logic [8:0]  gr [PN][64];
  int          grn [PN];
  logic [PN-1:0] auto_ack, man_ack;
  logic [8:0]  exp2 [6];
  int          vectors, miscompares;

  function automatic logic [47:0] tag_of(input logic [8:0] b);
    return 48'hA5A5_0000_0000 | {39'd0, b};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_h(input int p, input logic [2:0] t, input logic [8:0] b);
    hlist[p][hn[p]] = {t, b};
    hn[p]++;
  endtask

  task automatic add_n(input int p, input logic [2:0] t, input logic [8:0] b);
    nlist[p][nn[p]] = {t, b};
    nn[p]++;
  endtask

  task automatic present_all();
    logic [11:0] e;
    for (int p = 0; p < PN; p++) begin
      if (hi[p] < hn[p]) begin
        e = hlist[p][hi[p]];
        wr_h[p] = 1'b1;
        typ_h[p*3 +: 3] = e[11:9];
        buf_h[p*9 +: 9] = e[8:0];
        tag_h[p*48 +: 48] = tag_of(e[8:0]);
      end else begin
        wr_h[p] = 1'b0;
      end
      if (ni[p] < nn[p]) begin
        e = nlist[p][ni[p]];
        wr_n[p] = 1'b1;
        typ_n[p*3 +: 3] = e[11:9];
        buf_n[p*9 +: 9] = e[8:0];
        tag_n[p*48 +: 48] = tag_of(e[8:0]);
      end else begin
        wr_n[p] = 1'b0;
      end
    end
  endtask

  // One clock: sources react to acks, downstream ack is driven, pulses are logged.
  task automatic cycle();
    @(posedge clk);
    #1;
    for (int p = 0; p < PN; p++) begin
      if (wr_h[p] && ack_h[p]) begin
        if (grn[p] < 64) gr[p][grn[p]] = buf_h[p*9 +: 9];
        grn[p]++;
        hi[p]++;
      end
      if (wr_n[p] && ack_n[p]) begin
        if (grn[p] < 64) gr[p][grn[p]] = buf_n[p*9 +: 9];
        grn[p]++;
        ni[p]++;
      end
    end
    present_all();
    back = (auto_ack & bwr) | man_ack;
    #1;
    for (int p = 0; p < PN; p++) begin
      if (pulse[p]) begin
        if (gn[p] < 64) got[p][gn[p]] = obuf[p*9 +: 9];
        gn[p]++;
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    tag_h = '0; tag_n = '0; typ_h = '0; typ_n = '0; buf_h = '0; buf_n = '0;
    wr_h = '0; wr_n = '0; back = '0; gate = '1;
    auto_ack = '0; man_ack = '0;
    for (int p = 0; p < PN; p++) begin
      hn[p] = 0; hi[p] = 0; nn[p] = 0; ni[p] = 0; gn[p] = 0; grn[p] = 0;
    end
    rst = 1'b1;
    repeat (3) cycle();
    check("rst_bufid_wr", bwr, 0);
    check("rst_ack_host", ack_h, 0);
    check("rst_ack_net", ack_n, 0);
    check("rst_ts_used", ts_used, 0);
    check("rst_be_used", be_used, 0);
    check("rst_bufid", obuf, 0);
    check("rst_pulse", pulse, 0);
    rst = 1'b0;
    cycle();

    // Port 0: single TS descriptor, exact latency
    add_h(0, 3'd0, 9'h005);
    present_all();
    cycle();
    check("t1_ack_host", ack_h[0], 1);
    check("t1_ts_used", ts_used[0 +: UW], 1);
    check("t1_wr_not_yet", bwr[0], 0);
    cycle();
    check("t1_wr", bwr[0], 1);
    check("t1_bufid", obuf[0 +: 9], 9'h005);
    check("t1_type", otyp[0 +: 3], 0);
    check("t1_tsntag", otag[0 +: 48], tag_of(9'h005));
    check("t1_ts_used_popped", ts_used[0 +: UW], 0);
    cycle();
    check("t1_wr_hold", bwr[0], 1);
    check("t1_no_pulse", pulse[0], 0);
    man_ack[0] = 1'b1;
    cycle();
    check("t1_pulse", pulse[0], 1);
    man_ack[0] = 1'b0;
    cycle();
    check("t1_wr_low", bwr[0], 0);
    check("t1_pulse_low", pulse[0], 0);
    check("t1_count", gn[0], 1);
    check("t1_got", got[0][0], 9'h005);

    // Port 0: ack during LOAD is ignored
    add_h(0, 3'd1, 9'h006);
    present_all();
    cycle();
    man_ack[0] = 1'b1;
    cycle();
    check("load_ack_wr", bwr[0], 1);
    check("load_ack_ignored", pulse[0], 0);
    cycle();
    check("wait_ack_pulse", pulse[0], 1);
    man_ack[0] = 1'b0;
    cycle();
    check("wait_ack_wr_low", bwr[0], 0);

    // Port 1: round-robin between continuously requesting sources
    auto_ack[1] = 1'b1;
    add_h(1, 3'd4, 9'h010); add_h(1, 3'd4, 9'h011); add_h(1, 3'd4, 9'h012);
    add_n(1, 3'd5, 9'h020); add_n(1, 3'd5, 9'h021); add_n(1, 3'd5, 9'h022);
    present_all();
    repeat (30) cycle();
    exp2 = '{9'h010, 9'h020, 9'h011, 9'h021, 9'h012, 9'h022};
    check("rr_grants", grn[1], 6);
    check("rr_dispatches", gn[1], 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rr_grant_%0d", i), gr[1][i], exp2[i]);
      check($sformatf("rr_disp_%0d", i), got[1][i], exp2[i]);
    end

    // Port 2: BE held by closed gate, TS overtakes
    gate[2] = 1'b0;
    auto_ack[2] = 1'b1;
    add_h(2, 3'd3, 9'h030); add_h(2, 3'd6, 9'h031); add_h(2, 3'd7, 9'h032);
    present_all();
    repeat (8) cycle();
    check("gate_be_used", be_used[2*UW +: UW], 3);
    check("gate_no_disp", gn[2], 0);
    add_n(2, 3'd1, 9'h033);
    present_all();
    repeat (8) cycle();
    check("gate_ts_count", gn[2], 1);
    check("gate_ts_first", got[2][0], 9'h033);
    check("gate_be_still", be_used[2*UW +: UW], 3);
    gate[2] = 1'b1;
    repeat (20) cycle();
    check("gate_open_count", gn[2], 4);
    check("gate_be_0", got[2][1], 9'h030);
    check("gate_be_1", got[2][2], 9'h031);
    check("gate_be_2", got[2][3], 9'h032);

    // Port 3: fill TS, backpressure, pop-with-push, then pointer wrap
    for (int i = 0; i < 40; i++) add_h(3, 3'(i % 3), 9'(9'h040 + i));
    present_all();
    repeat (40) cycle();
    check("full_ts_used", ts_used[3*UW +: UW], 16);
    check("full_host_idx", hi[3], 17);
    check("full_wr_held", bwr[3], 1);
    check("full_no_disp", gn[3], 0);
    add_n(3, 3'd5, 9'h07F);
    present_all();
    repeat (3) cycle();
    check("full_be_accepted", ni[3], 1);
    check("full_be_used", be_used[3*UW +: UW], 1);
    check("full_ts_withheld", hi[3], 17);
    man_ack[3] = 1'b1;
    cycle();
    man_ack[3] = 1'b0;
    check("free_disp_count", gn[3], 1);
    check("free_disp_first", got[3][0], 9'h040);
    cycle();
    check("free_ts_not_yet", hi[3], 17);
    cycle();
    check("free_ts_accepted", hi[3], 18);
    auto_ack[3] = 1'b1;
    repeat (200) cycle();
    check("wrap_count", gn[3], 41);
    for (int i = 0; i < 40; i++) check($sformatf("wrap_%0d", i), got[3][i], 9'(9'h040 + i));
    check("wrap_be_last", got[3][40], 9'h07F);
    check("wrap_ts_empty", ts_used[3*UW +: UW], 0);
    check("wrap_be_empty", be_used[3*UW +: UW], 0);

    // Port 0: reset while waiting for ack with entries queued
    add_h(0, 3'd0, 9'h00A); add_h(0, 3'd1, 9'h00B); add_h(0, 3'd2, 9'h00C);
    present_all();
    repeat (8) cycle();
    check("rst_mid_wr", bwr[0], 1);
    check("rst_mid_used", ts_used[0 +: UW], 2);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_wr", bwr, 0);
    check("rst_async_used", ts_used, 0);
    check("rst_async_bufid", obuf, 0);
    cycle();
    rst = 1'b0;
    man_ack[0] = 1'b1;
    repeat (4) cycle();
    check("rst_after_pulse", pulse, 0);
    check("rst_after_wr", bwr, 0);
    check("rst_after_count", gn[0], 2);
    check("rst_after_used", ts_used[0 +: UW], 0);
    man_ack[0] = 1'b0;

    // All ports concurrently: TS from host, BE from network
    for (int p = 0; p < PN; p++) begin
      gn[p] = 0;
      for (int i = 0; i < 4; i++) begin
        add_h(p, 3'd0, 9'(9'h100 + 16*p + i));
        add_n(p, 3'd6, 9'(9'h180 + 16*p + i));
      end
    end
    auto_ack = '1;
    present_all();
    repeat (40) cycle();
    for (int p = 0; p < PN; p++) begin
      check($sformatf("multi_count_p%0d", p), gn[p], 8);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("multi_ts_p%0d_%0d", p, i), got[p][i], 9'(9'h100 + 16*p + i));
        check($sformatf("multi_be_p%0d_%0d", p, i), got[p][4+i], 9'(9'h180 + 16*p + i));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/network_output_desc_sched.md
# network_output_desc_sched

Parametrised per-port descriptor scheduler for the network output path, generalising the fixed two-port output stage to `PORT_NUM` ports. Each port merges descriptors from a host source and a network source, classifies them into time-sensitive (TS) and best-effort (BE) queues, and hands bufids to that port's packet-read stage. TS has strict priority, and a per-port BE gate controls when BE may go. It sits between the forwarding/lookup stage and the per-port packet read and GMII transmit logic.

## Interface
**Parameters**
- `PORT_NUM`, 2: number of output ports.
- `DESC_DEPTH`, 16: entries per class queue per port; power of two, ≥2.
- `TS_TYPE_MAX`, 3'd2: pkt_type ≤ this value is TS; anything higher is BE.

**Ports** (per-port vectors are flattened; port p occupies slice `[p*W +: W]`)
- `i_clk`  in  1  sole clock.
- `i_rst`  in  1  asynchronous, active-high reset.
- `iv_tsntag_host`  in  48*PORT_NUM  host descriptor tsntag.
- `iv_pkt_type_host`  in  3*PORT_NUM  host descriptor type.
- `iv_bufid_host`  in  9*PORT_NUM  host descriptor bufid.
- `i_descriptor_wr_host`  in  PORT_NUM  host descriptor request.
- `o_descriptor_ack_host`  out  PORT_NUM  host accept pulse.
- `iv_tsntag_network`, `iv_pkt_type_network`, `iv_bufid_network`, `i_descriptor_wr_network`, `o_descriptor_ack_network`: the same set for the network source.
- `iv_be_gate`  in  PORT_NUM  1 = BE dispatch allowed on that port.
- `ov_pkt_bufid`  out  9*PORT_NUM  dispatched bufid.
- `ov_tsntag`  out  48*PORT_NUM  dispatched tsntag.
- `ov_pkt_type`  out  3*PORT_NUM  dispatched type.
- `o_pkt_bufid_wr`  out  PORT_NUM  dispatch valid.
- `i_pkt_bufid_ack`  in  PORT_NUM  downstream accept pulse.
- `o_pkt_output_pulse`  out  PORT_NUM  one-cycle pulse per completed dispatch.
- `ov_ts_used`, `ov_be_used`  out  (log2(DESC_DEPTH)+1)*PORT_NUM  queue occupancy.

## Operation
Ports are fully independent; logic is replicated with a generate loop.

**Intake**
- Source s is eligible when its wr = 1, its ack register = 0, and its target queue is not full. The target is TS if pkt_type ≤ `TS_TYPE_MAX`, else BE.
- At most one descriptor is written per port per cycle.
- Round-robin pointer `rr` (0 = host, 1 = network) selects between sources:
  - Both eligible: grant `rr`, then invert `rr`.
  - One eligible: grant it; `rr` is set to the other source.
- Arbitration is work-conserving: a source blocked only by a full queue never stalls the other source.
- On grant, {tsntag, type, bufid} (60 bits) is pushed into the target queue and that source's ack pulses high for exactly one cycle.
- A source holds its data while wr is high and drops wr the cycle after it sees ack.

**Dispatch FSM** (per port): IDLE, LOAD, WAIT_ACK.
- IDLE
  - If TS is non-empty: pop TS head, go to LOAD.
  - Else if BE is non-empty and `iv_be_gate` = 1: pop BE head, go to LOAD.
- LOAD: output registers hold the popped entry; drive `o_pkt_bufid_wr` = 1; go to WAIT_ACK.
- WAIT_ACK
  - Hold outputs stable until `i_pkt_bufid_ack` = 1.
  - On that cycle, deassert wr at the next edge, pulse `o_pkt_output_pulse`, and return to IDLE.
- A descriptor is never preempted once loaded, even by a newly arrived TS entry or by the BE gate closing.
- An ack seen outside WAIT_ACK is ignored.

**Queues**
- Circular buffers with `log2(DESC_DEPTH)+1`-bit read/write pointers.
- Full when the low bits are equal and the MSBs differ; empty when the pointers are equal. Pointers wrap naturally.
- Push and pop in the same cycle on the same queue are legal. Occupancy is unchanged, and full does not block a push that coincides with a pop on that queue.

## Timing
- Reset: all outputs 0; queues empty; `rr` = host; FSM = IDLE.
- Reset asserted mid-operation flushes every queue and aborts any pending dispatch without an output pulse.
- Accept: wr sampled high at cycle t produces ack high at t+1 and queue non-empty at t+1.
- Earliest dispatch: pop at t+1 (IDLE), `o_pkt_bufid_wr` high at t+2.
- Dispatch cadence: after an ack at cycle k, wr is low at k+1. At least one idle cycle separates consecutive dispatches, giving a maximum of one descriptor per 3 cycles.
- Occupancy outputs are registered and reflect queue state after each edge.

## Test plan
1. Port 0 host sends type 0, bufid 0x005 → ack_host[0] at +1, wr[0] at +2 with bufid 0x005; ack at +4 → pulse[0] at +4, wr low at +5.
2. Host and network on port 1 both raise wr every cycle (types 4 and 5), with ack from downstream → grants alternate H, N, H, N starting with host; BE dispatch order matches.
3. BE queue holds 3 entries and `iv_be_gate` = 0; a TS entry (type 1) arrives → TS is dispatched first; no BE dispatched until gate = 1, then 3 BE dispatched in FIFO order.
4. Fill the TS queue to `DESC_DEPTH` with no downstream ack → used = 16, further TS acks withheld while a BE request is still accepted; one ack frees one slot → next TS accepted the following cycle. Run 40 entries through to check pointer wrap.
5. Assert `i_rst` while in WAIT_ACK with entries queued → all outputs 0 asynchronously; after release, queues are empty and no pulse is produced.
6. `PORT_NUM` = 4: independent traffic on all ports → no cross-port interference; each port's bufid order is correct.
